// File: rtl/user_seq_builder_pkg.sv
// Shared definitions for the user-sequence input stage.
// Holds digit/data widths, the FSM state encoding and the length clamp helper.
package user_seq_builder_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int MAX_DIGITS = 16;
    localparam int CNT_W      = 5;
    localparam int DATA_W     = NIBBLE_W * MAX_DIGITS;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    // Out-of-range lengths (0 or more than the register holds) fall back
    // to a full-width sequence.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] l);
        if (l == '0 || l > MAX_LEN) begin
            return MAX_LEN;
        end
        return l;
    endfunction

endpackage

// File: rtl/user_seq_builder_rise_detect.sv
// rise_detect: registered rising-edge detector for an already-clean button level.
// Ports: clk, R (sync active-high reset), level (button), press (one-cycle rise).
module rise_detect (
    input  logic clk,
    input  logic R,
    input  logic level,
    output logic press
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (R) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/user_seq_builder.sv
// user_seq_builder: collects switch digits on button presses, packs them into a
// 64-bit word and strobes E for one cycle when the programmed length is reached.
// Ports: clk, R (sync reset), start, abort, len, sw, enter -> data, E, count, busy.
module user_seq_builder
    import user_seq_builder_pkg::*;
(
    input  logic                clk,
    input  logic                R,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    len,
    input  logic [NIBBLE_W-1:0] sw,
    input  logic                enter,
    output logic [DATA_W-1:0]   data,
    output logic                E,
    output logic [CNT_W-1:0]    count,
    output logic                busy
);

    state_t             state;
    state_t             state_n;
    logic [DATA_W-1:0]  data_n;
    logic [CNT_W-1:0]   count_n;
    logic [CNT_W-1:0]   count_inc;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   len_n;
    logic               press;

    rise_detect u_enter_rise (
        .clk   (clk),
        .R     (R),
        .level (enter),
        .press (press)
    );

    assign count_inc = count + CNT_W'(1);

    always_comb begin
        state_n = state;
        data_n  = data;
        count_n = count;
        len_n   = len_q;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    len_n   = clamp_len(len);
                    data_n  = '0;
                    count_n = '0;
                    state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // abort beats start beats press
                if (abort) begin
                    data_n  = '0;
                    count_n = '0;
                    state_n = ST_IDLE;
                end else if (start) begin
                    len_n   = clamp_len(len);
                    data_n  = '0;
                    count_n = '0;
                end else if (press) begin
                    data_n  = {data[DATA_W-NIBBLE_W-1:0], sw};
                    count_n = count_inc;
                    if (count_inc == len_q) begin
                        state_n = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // E and busy are decoded from the next state so they are plain flops
    // aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (R) begin
            state <= ST_IDLE;
            data  <= '0;
            count <= '0;
            len_q <= '0;
            E     <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            data  <= data_n;
            count <= count_n;
            len_q <= len_n;
            E     <= (state_n == ST_LOAD);
            busy  <= (state_n == ST_CAPTURE);
        end
    end

endmodule
